redraw_scheduler: RTL

//  Sequences all partial and full screen redraws into the single shared draw engine.

---
 rtl/redraw_scheduler_if.sv | 19 +
 rtl/redraw_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/redraw_scheduler_if.sv
// rtl/redraw_scheduler_if.sv - command/completion bus between the redraw scheduler and the draw engine
interface redraw_scheduler_if;
  logic       draw_valid;
  logic [1:0] draw_op;
  logic [3:0] draw_row;
  logic [3:0] draw_col;
  logic       draw_ready;
  logic       draw_done;

  modport master (
    output draw_valid, draw_op, draw_row, draw_col,
    input  draw_ready, draw_done
  );

  modport slave (
    input  draw_valid, draw_op, draw_row, draw_col,
    output draw_ready, draw_done
  );
endinterface

// File: rtl/redraw_scheduler.sv
// rtl/redraw_scheduler.sv - serialises board, cell and cursor redraws into the shared draw engine
module redraw_scheduler #(
  parameter int CELL_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               board_req,
  input  logic               cell_req,
  input  logic [3:0]         cell_row,
  input  logic [3:0]         cell_col,
  input  logic               cursor_req,
  input  logic [3:0]         cursor_row,
  input  logic [3:0]         cursor_col,
  redraw_scheduler_if.master draw,
  output logic               cursor_ack,
  output logic               busy,
  output logic               timeout_err
);
  localparam int AW = $clog2(CELL_FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] OP_BOARD = 2'b00;
  localparam logic [1:0] OP_CELL  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_DRAW  = 2'b11;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(CELL_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q;
  logic          valid_q, ack_q, timeout_err_q;
  logic          board_pend_q, cur_drawn_q, cur_force_q, cursor_req_q;
  logic [1:0]    op_q;
  logic [3:0]    row_q, col_q, last_row_q, last_col_q, new_row_q, new_col_q;
  logic [TW-1:0] timer_q;

  logic [7:0]    fifo_mem [CELL_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic done_evt, timeout_hit, op_finish, pop, board_fin, push_ok;

  assign done_evt    = (state_q == WAIT) && draw.draw_done;
  assign timeout_hit = (state_q == WAIT) && !draw.draw_done && (timer_q == TIMER_LAST);
  assign op_finish   = done_evt || timeout_hit;
  assign pop         = (state_q == ISSUE) && draw.draw_ready && (op_q == OP_CELL);
  assign board_fin   = op_finish && (op_q == OP_BOARD);
  // The board flush empties the queue first, so a push landing on that edge always fits
  assign push_ok     = cell_req && ((count_q != FIFO_FULL) || pop || board_fin);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (board_fin) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - (AW + 1)'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {cell_row, cell_col};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      valid_q       <= 1'b0;
      op_q          <= OP_BOARD;
      row_q         <= '0;
      col_q         <= '0;
      timer_q       <= '0;
      board_pend_q  <= 1'b1;
      cur_drawn_q   <= 1'b0;
      cur_force_q   <= 1'b0;
      cursor_req_q  <= 1'b0;
      last_row_q    <= '0;
      last_col_q    <= '0;
      new_row_q     <= '0;
      new_col_q     <= '0;
      ack_q         <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_q        <= 1'b0;
      cursor_req_q <= cursor_req;
      case (state_q)
        IDLE: begin
          if (board_pend_q) begin
            op_q    <= OP_BOARD;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end else if (count_q != '0) begin
            op_q    <= OP_CELL;
            row_q   <= fifo_mem[rd_ptr_q][7:4];
            col_q   <= fifo_mem[rd_ptr_q][3:0];
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end else if (cur_force_q || cursor_req_q) begin
            new_row_q <= cursor_row;
            new_col_q <= cursor_col;
            op_q      <= cur_drawn_q ? OP_ERASE : OP_DRAW;
            row_q     <= cur_drawn_q ? last_row_q : cursor_row;
            col_q     <= cur_drawn_q ? last_col_q : cursor_col;
            valid_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (draw.draw_ready) begin
            valid_q <= 1'b0;
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (op_finish) begin
            state_q <= IDLE;
            if (timeout_hit) timeout_err_q <= 1'b1;
            case (op_q)
              OP_BOARD: begin
                board_pend_q <= 1'b0;
                cur_drawn_q  <= 1'b0;
                cur_force_q  <= 1'b1;
              end
              OP_ERASE: begin
                if (done_evt) begin
                  op_q    <= OP_DRAW;
                  row_q   <= new_row_q;
                  col_q   <= new_col_q;
                  valid_q <= 1'b1;
                  state_q <= ISSUE;
                end else begin
                  cur_drawn_q <= 1'b0;
                end
              end
              OP_DRAW: begin
                last_row_q  <= new_row_q;
                last_col_q  <= new_col_q;
                cur_drawn_q <= 1'b1;
                cur_force_q <= 1'b0;
                if (done_evt) begin
                  ack_q        <= 1'b1;
                  cursor_req_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      // New requests outrank the clear from a finishing board redraw
      if (board_req || (cell_req && !push_ok)) board_pend_q <= 1'b1;
    end
  end

  assign draw.draw_valid = valid_q;
  assign draw.draw_op    = op_q;
  assign draw.draw_row   = row_q;
  assign draw.draw_col   = col_q;
  assign cursor_ack      = ack_q;
  assign busy            = (state_q != IDLE);
  assign timeout_err     = timeout_err_q;
endmodule
